// File: rtl/event_pending_ctrl.sv
// event_pending_ctrl: captures rising edges on 8 event lines into sticky,
// maskable pending bits. The masked pending vector goes out to an external
// 8-to-3 priority encoder (bit 7 highest), whose index is read back. One
// pending event at a time is then offered on a valid/ready port.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   evt[7:0]          synchronous event lines; a 0->1 transition sets pending
//   mask_we/wdata     mask load, takes effect at the next edge
//   mask[7:0]         current enable mask (1 = line enabled)
//   pend_vec[7:0]     pending & mask, combinational, feeds encoder.in
//   enc_idx[2:0]      encoder.out, valid in the same cycle as pend_vec
//   req_valid/idx     offered event index
//   req_ready         consumer accepts the offer
//   overflow[7:0]     sticky: edge arrived while the line was already pending
//   ovf_clr           clears all overflow bits (a coincident new set wins)
module event_pending_ctrl #(
  parameter logic [7:0] MASK_RST = 8'hFF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] evt,
  input  logic       mask_we,
  input  logic [7:0] mask_wdata,
  output logic [7:0] mask,
  output logic [7:0] pend_vec,
  input  logic [2:0] enc_idx,
  output logic       req_valid,
  output logic [2:0] req_idx,
  input  logic       req_ready,
  output logic [7:0] overflow,
  input  logic       ovf_clr
);

  typedef enum logic {IDLE, OFFER} state_t;

  state_t     state_q, state_d;
  logic [7:0] evt_q;
  logic [7:0] pending_q, pending_d;
  logic [7:0] mask_q, mask_d;
  logic [7:0] overflow_q, overflow_d;
  logic [2:0] req_idx_q, req_idx_d;

  logic [7:0] evt_edge;
  logic [7:0] clr;
  logic [7:0] ovf_set;

  assign evt_edge = evt & ~evt_q;

  // The accepted line is cleared regardless of the mask, so an offer that
  // gets masked after it was made still retires its own pending bit.
  assign clr = (state_q == OFFER && req_ready) ? (8'b1 << req_idx_q) : 8'b0;

  // A new edge on a line being accepted this cycle re-arms it; that is not
  // an overflow because the previous occurrence is being consumed.
  assign ovf_set   = evt_edge & pending_q & ~clr;
  assign pending_d = (pending_q & ~clr) | evt_edge;
  assign overflow_d = ovf_clr ? ovf_set : (overflow_q | ovf_set);
  assign mask_d     = mask_we ? mask_wdata : mask_q;

  assign pend_vec  = pending_q & mask_q;
  assign mask      = mask_q;
  assign overflow  = overflow_q;
  // Decoded from state so an asynchronous reset drops the offer at once.
  assign req_valid = (state_q == OFFER);
  assign req_idx   = req_idx_q;

  always_comb begin
    state_d   = state_q;
    req_idx_d = req_idx_q;
    unique case (state_q)
      IDLE: begin
        // Priority is frozen here; later arrivals wait for the next IDLE.
        if (pend_vec != 8'b0) begin
          req_idx_d = enc_idx;
          state_d   = OFFER;
        end
      end
      OFFER: begin
        if (req_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      evt_q      <= 8'b0;
      pending_q  <= 8'b0;
      mask_q     <= MASK_RST;
      overflow_q <= 8'b0;
      req_idx_q  <= 3'd0;
    end else begin
      state_q    <= state_d;
      evt_q      <= evt;
      pending_q  <= pending_d;
      mask_q     <= mask_d;
      overflow_q <= overflow_d;
      req_idx_q  <= req_idx_d;
    end
  end

endmodule

// File: tb/tb_event_pending_ctrl.sv
// Directed bench for event_pending_ctrl. A behavioural 8-to-3 priority
// encoder closes the pend_vec -> enc_idx loop. Inputs change and outputs are
// sampled 1 time unit after each rising edge.
module tb_event_pending_ctrl;

  logic       clk;
  logic       rst_n;
  logic [7:0] evt;
  logic       mask_we;
  logic [7:0] mask_wdata;
  logic [7:0] mask;
  logic [7:0] pend_vec;
  logic [2:0] enc_idx;
  logic       req_valid;
  logic [2:0] req_idx;
  logic       req_ready;
  logic [7:0] overflow;
  logic       ovf_clr;

  int checks = 0;
  int errors = 0;
  int offers;

  event_pending_ctrl #(.MASK_RST(8'hFF)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .evt        (evt),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .mask       (mask),
    .pend_vec   (pend_vec),
    .enc_idx    (enc_idx),
    .req_valid  (req_valid),
    .req_idx    (req_idx),
    .req_ready  (req_ready),
    .overflow   (overflow),
    .ovf_clr    (ovf_clr)
  );

  // External priority encoder, bit 7 highest.
  always_comb begin
    enc_idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (pend_vec[i]) enc_idx = i[2:0];
    end
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    evt        = 8'h00;
    mask_we    = 1'b0;
    mask_wdata = 8'h00;
    req_ready  = 1'b0;
    ovf_clr    = 1'b0;
    tick();
    tick();
    chk("rst_mask", mask, 8'hFF);
    chk("rst_pend_vec", pend_vec, 8'h00);
    chk("rst_overflow", overflow, 8'h00);
    chk("rst_req_valid", {7'b0, req_valid}, 8'h00);
    chk("rst_req_idx", {5'b0, req_idx}, 8'h00);
    rst_n = 1'b1;
    tick();

    // Priority order: A0 pulse, ready held high.
    req_ready = 1'b1;
    evt = 8'hA0;
    tick();
    evt = 8'h00;
    chk("prio_pend_vec", pend_vec, 8'hA0);
    chk("prio_valid0", {7'b0, req_valid}, 8'h00);
    tick();
    chk("prio_valid_a", {7'b0, req_valid}, 8'h01);
    chk("prio_idx7", {5'b0, req_idx}, 8'h07);
    tick();
    chk("prio_gap_valid", {7'b0, req_valid}, 8'h00);
    chk("prio_pend_after7", pend_vec, 8'h20);
    tick();
    chk("prio_valid_b", {7'b0, req_valid}, 8'h01);
    chk("prio_idx5", {5'b0, req_idx}, 8'h05);
    tick();
    chk("prio_pend_end", pend_vec, 8'h00);
    chk("prio_valid_end", {7'b0, req_valid}, 8'h00);
    tick();
    chk("prio_idle", {7'b0, req_valid}, 8'h00);

    // Backpressure and late higher-priority arrival.
    req_ready = 1'b0;
    evt = 8'h01;
    tick();
    evt = 8'h00;
    tick();
    chk("bp_valid", {7'b0, req_valid}, 8'h01);
    chk("bp_idx0", {5'b0, req_idx}, 8'h00);
    repeat (5) tick();
    evt = 8'h80;
    tick();
    evt = 8'h00;
    chk("bp_pend_vec", pend_vec, 8'h81);
    chk("bp_idx_held", {5'b0, req_idx}, 8'h00);
    tick();
    chk("bp_valid_held", {7'b0, req_valid}, 8'h01);
    chk("bp_idx_held2", {5'b0, req_idx}, 8'h00);
    req_ready = 1'b1;
    tick();
    chk("bp_accept0", {7'b0, req_valid}, 8'h00);
    chk("bp_pend_after0", pend_vec, 8'h80);
    tick();
    chk("bp_valid7", {7'b0, req_valid}, 8'h01);
    chk("bp_idx7", {5'b0, req_idx}, 8'h07);
    tick();
    chk("bp_pend_end", pend_vec, 8'h00);

    // Masking: bit 0 hidden, then exposed.
    mask_we = 1'b1;
    mask_wdata = 8'hFE;
    tick();
    mask_we = 1'b0;
    chk("msk_mask", mask, 8'hFE);
    evt = 8'h05;
    tick();
    evt = 8'h00;
    chk("msk_pend_vec", pend_vec, 8'h04);
    tick();
    chk("msk_valid2", {7'b0, req_valid}, 8'h01);
    chk("msk_idx2", {5'b0, req_idx}, 8'h02);
    tick();
    chk("msk_pend_hidden", pend_vec, 8'h00);
    tick();
    chk("msk_no_offer", {7'b0, req_valid}, 8'h00);
    mask_we = 1'b1;
    mask_wdata = 8'hFF;
    tick();
    mask_we = 1'b0;
    chk("msk_exposed", pend_vec, 8'h01);
    tick();
    chk("msk_valid0", {7'b0, req_valid}, 8'h01);
    chk("msk_idx0", {5'b0, req_idx}, 8'h00);
    tick();
    chk("msk_pend_end", pend_vec, 8'h00);

    // Overflow, clear, and edge coinciding with accept.
    req_ready = 1'b0;
    evt = 8'h08;
    tick();
    evt = 8'h00;
    tick();
    evt = 8'h08;
    tick();
    evt = 8'h00;
    tick();
    chk("ovf_set", overflow, 8'h08);
    chk("ovf_valid", {7'b0, req_valid}, 8'h01);
    chk("ovf_idx3", {5'b0, req_idx}, 8'h03);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("ovf_cleared", overflow, 8'h00);
    req_ready = 1'b1;
    evt = 8'h08;
    tick();
    evt = 8'h00;
    req_ready = 1'b0;
    chk("ovf_edge_wins", pend_vec, 8'h08);
    chk("ovf_no_flag", overflow, 8'h00);
    chk("ovf_accepted", {7'b0, req_valid}, 8'h00);
    tick();
    chk("ovf_reoffer", {7'b0, req_valid}, 8'h01);
    chk("ovf_reoffer_idx", {5'b0, req_idx}, 8'h03);
    req_ready = 1'b1;
    tick();
    chk("ovf_pend_end", pend_vec, 8'h00);

    // Held level: one edge, exactly one offer.
    offers = 0;
    evt = 8'h10;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (req_valid) begin
        offers++;
        chk("held_idx4", {5'b0, req_idx}, 8'h04);
      end
    end
    evt = 8'h00;
    tick();
    chk("held_offers", offers[7:0], 8'h01);
    chk("held_pend_end", pend_vec, 8'h00);

    // Reset asserted mid-cycle during an offer.
    req_ready = 1'b0;
    mask_we = 1'b1;
    mask_wdata = 8'h7F;
    tick();
    mask_we = 1'b0;
    evt = 8'h02;
    tick();
    evt = 8'h00;
    tick();
    evt = 8'h02;
    tick();
    evt = 8'h00;
    chk("pre_rst_valid", {7'b0, req_valid}, 8'h01);
    chk("pre_rst_idx", {5'b0, req_idx}, 8'h01);
    chk("pre_rst_ovf", overflow, 8'h02);
    chk("pre_rst_mask", mask, 8'h7F);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", {7'b0, req_valid}, 8'h00);
    chk("arst_pend_vec", pend_vec, 8'h00);
    chk("arst_mask", mask, 8'hFF);
    chk("arst_ovf", overflow, 8'h00);
    chk("arst_idx", {5'b0, req_idx}, 8'h00);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    chk("post_rst_valid", {7'b0, req_valid}, 8'h00);
    chk("post_rst_pend_vec", pend_vec, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
